ppu_id_ex_stage: RTL and testbench

ID/EX pipeline stage register for the PPU pipeline. It sits directly downstream of `PPU_Control_Unit`, latching the 22-bit control word together with the ID-stage operands into the EX stage. It detects load-use hazards and inserts bubbles for them. It honours branch flushes and downstream holds, and counts every inserted bubble.

---
 rtl/ppu_pkg.sv | 12 +
 rtl/ppu_load_use_detect.sv | 25 ++
 rtl/ppu_id_ex_stage.sv | 123 ++++++++++++
 tb/tb_ppu_id_ex_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: control-word layout and register constants shared by the PPU pipeline.
package ppu_pkg;
   localparam int CS_W      = 22;
   localparam int CS_MEM_EN = 0;
   localparam int CS_MEM_RW = 4;
   localparam int CS_LOAD   = 10;
   localparam int CS_DEST   = 18;
   localparam int CS_UJUMP  = 19;
   localparam int CS_R31    = 20;
   localparam int CS_COND   = 21;
   localparam logic [4:0] REG_RA = 5'd31;
endpackage

// File: rtl/ppu_load_use_detect.sv
// ppu_load_use_detect: load-use hazard against the EX load and ID destination select.
module ppu_load_use_detect
   import ppu_pkg::*;
(
   input  logic       ex_valid,
   input  logic       ex_mem_en,
   input  logic       ex_mem_rw,
   input  logic [4:0] ex_dest,
   input  logic       id_valid,
   input  logic [5:0] id_opcode,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic [4:0] id_rd,
   input  logic       id_jal,
   input  logic       flush_any,
   output logic       hazard,
   output logic [4:0] id_dest
);
   logic ex_is_load;
   assign ex_is_load = ex_valid & ex_mem_en & ~ex_mem_rw;
   // A flushed ID instruction never executes, so it cannot create a hazard.
   assign hazard = ex_is_load & (ex_dest != 5'd0) & ((ex_dest == id_rs) | (ex_dest == id_rt))
                   & id_valid & ~flush_any;
   assign id_dest = id_jal ? REG_RA : (id_opcode == 6'd0) ? id_rd : id_rt;
endmodule

// File: rtl/ppu_id_ex_stage.sv
// ppu_id_ex_stage: ID/EX pipeline register with load-use bubbles, flush/hold handling
// and a saturating bubble counter.
module ppu_id_ex_stage
   import ppu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [31:0]       id_instruction,
   input  logic [CS_W-1:0]   id_control_signals,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic              id_flush,
   input  logic              ex_hold,
   output logic              id_stall,
   output logic              ex_valid,
   output logic [CS_W-1:0]   ex_control_signals,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_dest_reg,
   output logic [CNT_W-1:0]  bubble_count
);
   logic              valid_q, valid_d;
   logic [CS_W-1:0]   cs_q, cs_d;
   logic [DATA_W-1:0] pc_q, pc_d, rs_q, rs_d, rt_q, rt_d, imm_q, imm_d;
   logic [4:0]        dest_q, dest_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              pending_flush_q, pending_flush_d;
   logic              hazard, flush_any;
   logic [4:0]        id_dest;

   assign flush_any = id_flush | pending_flush_q;
   assign cnt_inc   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);

   ppu_load_use_detect u_detect (
      .ex_valid  (valid_q),
      .ex_mem_en (cs_q[CS_MEM_EN]),
      .ex_mem_rw (cs_q[CS_MEM_RW]),
      .ex_dest   (dest_q),
      .id_valid  (id_valid),
      .id_opcode (id_instruction[31:26]),
      .id_rs     (id_instruction[25:21]),
      .id_rt     (id_instruction[20:16]),
      .id_rd     (id_instruction[15:11]),
      .id_jal    (id_control_signals[CS_R31] & id_control_signals[CS_UJUMP]),
      .flush_any (flush_any),
      .hazard    (hazard),
      .id_dest   (id_dest)
   );

   always_comb begin
      valid_d         = valid_q;
      cs_d            = cs_q;
      pc_d            = pc_q;
      rs_d            = rs_q;
      rt_d            = rt_q;
      imm_d           = imm_q;
      dest_d          = dest_q;
      cnt_d           = cnt_q;
      pending_flush_d = pending_flush_q;
      if (ex_hold) begin
         pending_flush_d = pending_flush_q | id_flush;
      end else if (flush_any | hazard) begin
         valid_d         = 1'b0;
         cs_d            = '0;
         pc_d            = '0;
         rs_d            = '0;
         rt_d            = '0;
         imm_d           = '0;
         dest_d          = '0;
         pending_flush_d = 1'b0;
         cnt_d           = cnt_inc;
      end else begin
         valid_d = id_valid & (id_instruction != 32'd0);
         cs_d    = id_control_signals;
         pc_d    = id_pc;
         rs_d    = id_rs_data;
         rt_d    = id_rt_data;
         imm_d   = {{(DATA_W-16){id_instruction[15]}}, id_instruction[15:0]};
         dest_d  = id_dest;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q         <= 1'b0;
         cs_q            <= '0;
         pc_q            <= '0;
         rs_q            <= '0;
         rt_q            <= '0;
         imm_q           <= '0;
         dest_q          <= '0;
         cnt_q           <= '0;
         pending_flush_q <= 1'b0;
      end else begin
         valid_q         <= valid_d;
         cs_q            <= cs_d;
         pc_q            <= pc_d;
         rs_q            <= rs_d;
         rt_q            <= rt_d;
         imm_q           <= imm_d;
         dest_q          <= dest_d;
         cnt_q           <= cnt_d;
         pending_flush_q <= pending_flush_d;
      end
   end

   assign id_stall           = hazard | ex_hold;
   assign ex_valid           = valid_q;
   assign ex_control_signals = cs_q;
   assign ex_pc              = pc_q;
   assign ex_rs_data         = rs_q;
   assign ex_rt_data         = rt_q;
   assign ex_imm             = imm_q;
   assign ex_dest_reg        = dest_q;
   assign bubble_count       = cnt_q;
endmodule

// File: tb/tb_ppu_id_ex_stage.sv
// tb_ppu_id_ex_stage: directed checks of the ID/EX stage with CNT_W=4.
module tb_ppu_id_ex_stage;
   localparam logic [21:0] CS_LW    = 22'h000401;
   localparam logic [21:0] CS_ADDIU = 22'h040400;
   localparam logic [21:0] CS_RTYPE = 22'h040000;
   localparam logic [21:0] CS_JAL   = 22'h180000;
   localparam logic [31:0] I_LW8    = 32'h8D28_0000;
   localparam logic [31:0] I_SUBU   = 32'h010B_5023;
   localparam logic [31:0] I_ADDIU  = 32'h2402_FFFF;
   localparam logic [31:0] I_LW0    = 32'h8D20_0004;
   localparam logic [31:0] I_ADDU0  = 32'h0000_1821;
   localparam logic [31:0] I_JAL    = 32'h0C00_0010;
   localparam logic [31:0] I_LW31   = 32'h8FBF_0000;
   localparam logic [31:0] I_JR31   = 32'h03E0_0008;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [31:0] id_instruction = '0;
   logic [21:0] id_control_signals = '0;
   logic [31:0] id_pc = '0, id_rs_data = '0, id_rt_data = '0;
   logic        id_flush = 1'b0, ex_hold = 1'b0;
   logic        id_stall, ex_valid;
   logic [21:0] ex_control_signals;
   logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_dest_reg;
   logic [3:0]  bubble_count;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ppu_id_ex_stage #(.DATA_W(32), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_instruction(id_instruction),
      .id_control_signals(id_control_signals), .id_pc(id_pc), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_flush(id_flush), .ex_hold(ex_hold), .id_stall(id_stall),
      .ex_valid(ex_valid), .ex_control_signals(ex_control_signals), .ex_pc(ex_pc),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_dest_reg(ex_dest_reg), .bubble_count(bubble_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] ins, input logic [21:0] cs,
                         input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt);
      id_valid = v; id_instruction = ins; id_control_signals = cs;
      id_pc = pc; id_rs_data = rs; id_rt_data = rt;
      #1;
   endtask

   task automatic do_reset();
      id_flush = 1'b0; ex_hold = 1'b0;
      set_id(1'b0, 32'd0, 22'd0, 32'd0, 32'd0, 32'd0);
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      set_id(1'b1, I_ADDIU, CS_ADDIU, 32'h100, 32'h11, 32'h22);
      step();
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", ex_valid); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ex_valid); end
      checks++; if (ex_pc !== 32'd0 || ex_imm !== 32'd0 || ex_dest_reg !== 5'd0 || ex_control_signals !== 22'd0)
         begin errors++; $display("FAIL rst_fields got pc=%h imm=%h dest=%0d cs=%h want 0", ex_pc, ex_imm, ex_dest_reg, ex_control_signals); end
      checks++; if (bubble_count !== 4'd0 || id_stall !== 1'b0)
         begin errors++; $display("FAIL rst_cnt_stall got cnt=%0d stall=%b want 0 0", bubble_count, id_stall); end
      reset_n = 1'b1;
      step();
      checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_imm !== 32'hFFFF_FFFF || ex_dest_reg !== 5'd2)
         begin errors++; $display("FAIL rst_addiu got v=%b pc=%h imm=%h dest=%0d want 1 100 ffffffff 2", ex_valid, ex_pc, ex_imm, ex_dest_reg); end
      checks++; if (ex_rs_data !== 32'h11 || ex_rt_data !== 32'h22 || ex_control_signals !== CS_ADDIU)
         begin errors++; $display("FAIL rst_addiu_data got rs=%h rt=%h cs=%h", ex_rs_data, ex_rt_data, ex_control_signals); end
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1'b1, I_LW8, CS_LW, 32'h200, 32'h9, 32'h0);
      step();
      checks++; if (ex_dest_reg !== 5'd8) begin errors++; $display("FAIL lu_lw_dest got %0d want 8", ex_dest_reg); end
      set_id(1'b1, I_SUBU, CS_RTYPE, 32'h204, 32'hAA, 32'hBB);
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", id_stall); end
      step();
      checks++; if (ex_valid !== 1'b0 || ex_control_signals !== 22'd0 || ex_pc !== 32'd0 || ex_dest_reg !== 5'd0)
         begin errors++; $display("FAIL lu_bubble got v=%b cs=%h pc=%h dest=%0d want 0", ex_valid, ex_control_signals, ex_pc, ex_dest_reg); end
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_drop got %b want 0", id_stall); end
      step();
      checks++; if (ex_valid !== 1'b1 || ex_dest_reg !== 5'd10 || ex_pc !== 32'h204 || ex_rs_data !== 32'hAA)
         begin errors++; $display("FAIL lu_subu got v=%b dest=%0d pc=%h rs=%h want 1 10 204 aa", ex_valid, ex_dest_reg, ex_pc, ex_rs_data); end
      checks++; if (bubble_count !== 4'd1) begin errors++; $display("FAIL lu_count got %0d want 1", bubble_count); end
   endtask

   task automatic test_zero_reg();
      do_reset();
      set_id(1'b1, I_LW0, CS_LW, 32'h300, 32'h9, 32'h0);
      step();
      set_id(1'b1, I_ADDU0, CS_RTYPE, 32'h304, 32'h0, 32'h0);
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL zr_stall got %b want 0", id_stall); end
      step();
      checks++; if (ex_valid !== 1'b1 || ex_dest_reg !== 5'd3 || bubble_count !== 4'd0)
         begin errors++; $display("FAIL zr_addu got v=%b dest=%0d cnt=%0d want 1 3 0", ex_valid, ex_dest_reg, bubble_count); end
      set_id(1'b1, 32'd0, 22'd0, 32'h308, 32'h0, 32'h0);
      step();
      checks++; if (ex_valid !== 1'b0 || bubble_count !== 4'd0)
         begin errors++; $display("FAIL zr_nop got v=%b cnt=%0d want 0 0", ex_valid, bubble_count); end
   endtask

   task automatic test_jal();
      do_reset();
      set_id(1'b1, I_JAL, CS_JAL, 32'h400, 32'h0, 32'h0);
      step();
      checks++; if (ex_dest_reg !== 5'd31 || ex_valid !== 1'b1)
         begin errors++; $display("FAIL jal_dest got dest=%0d v=%b want 31 1", ex_dest_reg, ex_valid); end
      set_id(1'b1, I_LW31, CS_LW, 32'h404, 32'h0, 32'h0);
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL jal_nostall got %b want 0", id_stall); end
      step();
      set_id(1'b1, I_JR31, CS_RTYPE, 32'h408, 32'h0, 32'h0);
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL jr_stall got %b want 1", id_stall); end
   endtask

   task automatic test_flush_under_hold();
      do_reset();
      set_id(1'b1, I_ADDIU, CS_ADDIU, 32'h500, 32'h1, 32'h2);
      step();
      set_id(1'b1, I_SUBU, CS_RTYPE, 32'h504, 32'h3, 32'h4);
      ex_hold = 1'b1; id_flush = 1'b1;
      #1;
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL fh_stall got %b want 1", id_stall); end
      for (int i = 0; i < 3; i++) begin
         step();
         id_flush = 1'b0;
         checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h500 || bubble_count !== 4'd0)
            begin errors++; $display("FAIL fh_hold%0d got v=%b pc=%h cnt=%0d want 1 500 0", i, ex_valid, ex_pc, bubble_count); end
      end
      ex_hold = 1'b0;
      step();
      checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'd0 || bubble_count !== 4'd1)
         begin errors++; $display("FAIL fh_bubble got v=%b pc=%h cnt=%0d want 0 0 1", ex_valid, ex_pc, bubble_count); end
      step();
      checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h504 || bubble_count !== 4'd1)
         begin errors++; $display("FAIL fh_resume got v=%b pc=%h cnt=%0d want 1 504 1", ex_valid, ex_pc, bubble_count); end
   endtask

   task automatic test_hazard_combos();
      do_reset();
      set_id(1'b1, I_LW8, CS_LW, 32'h600, 32'h0, 32'h0);
      step();
      set_id(1'b1, I_SUBU, CS_RTYPE, 32'h604, 32'h0, 32'h0);
      ex_hold = 1'b1;
      step();
      checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h600 || bubble_count !== 4'd0 || id_stall !== 1'b1)
         begin errors++; $display("FAIL hh got v=%b pc=%h cnt=%0d stall=%b want 1 600 0 1", ex_valid, ex_pc, bubble_count, id_stall); end
      ex_hold = 1'b0; id_flush = 1'b1;
      #1;
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL fz_stall got %b want 0", id_stall); end
      step();
      id_flush = 1'b0;
      checks++; if (ex_valid !== 1'b0 || bubble_count !== 4'd1)
         begin errors++; $display("FAIL fz_bubble got v=%b cnt=%0d want 0 1", ex_valid, bubble_count); end
   endtask

   task automatic test_saturation();
      do_reset();
      id_flush = 1'b1;
      for (int i = 0; i < 14; i++) step();
      checks++; if (bubble_count !== 4'd14) begin errors++; $display("FAIL sat14 got %0d want 14", bubble_count); end
      step();
      checks++; if (bubble_count !== 4'd15) begin errors++; $display("FAIL sat15 got %0d want 15", bubble_count); end
      for (int i = 0; i < 5; i++) step();
      checks++; if (bubble_count !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", bubble_count); end
      id_flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_zero_reg();
      test_jal();
      test_flush_under_hold();
      test_hazard_combos();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
